sc_imem_loader: RTL and testbench

- Writable instruction memory with a byte-stream program loader; the write-side counterpart of the single-cycle instruction ROM.
- A host (UART/debug bridge) streams bytes over a valid/ready handshake; the block packs them big-endian into 32-bit words and writes consecutive word addresses from 0.
- The CPU reads through a combinational fetch port.
- `busy` stalls the CPU while loading.

---
 rtl/sc_imem_loader.sv | 126 ++++++++++++
 tb/tb_sc_imem_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sc_imem_loader.sv
// Writable instruction memory fed by a big-endian byte-stream loader, with a combinational fetch port.
// Define SC_IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after each load.
module sc_imem_loader #(
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic [AW:0]   load_len,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  input  logic [31:0]   a,
  output logic [31:0]   inst,
  output logic          busy,
  output logic          done,
  output logic          load_err
);

  localparam int unsigned Depth = 2 ** AW;

  typedef enum logic [1:0] {StIdle, StLoad, StCheck, StDone} state_e;

  state_e          state_q, state_d;
  logic [1:0]      pos_q;
  logic [AW-1:0]   idx_q;
  logic [AW-1:0]   last_q;
  logic [AW-1:0]   last_d;
  logic [23:0]     hold_q;
  logic [31:0]     mem [Depth];
  logic            xfer;
  logic            start_ok;
  logic            word_end;

  assign xfer     = byte_valid & byte_ready;
  assign start_ok = (state_q == StIdle) & load_start;
  assign word_end = (state_q == StLoad) & xfer & (pos_q == 2'd3);

  // Zero or anything above the depth means a full-memory load.
  assign last_d = ((load_len == '0) || load_len[AW]) ? '1 : (load_len[AW-1:0] - AW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (load_start) state_d = StLoad;
      StLoad: begin
        if (word_end && (idx_q == last_q)) begin
`ifdef SC_IMEM_LOADER_CHECKSUM_EN
          state_d = StCheck;
`else
          state_d = StDone;
`endif
        end
      end
      StCheck: if (xfer) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    byte_ready = (state_q == StLoad) || (state_q == StCheck);
    busy       = byte_ready;
    done       = (state_q == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q  <= 2'd0;
      idx_q  <= '0;
      last_q <= '0;
      hold_q <= '0;
    end else if (start_ok) begin
      pos_q  <= 2'd0;
      idx_q  <= '0;
      last_q <= last_d;
    end else if ((state_q == StLoad) && xfer) begin
      pos_q <= pos_q + 2'd1;
      case (pos_q)
        2'd0: hold_q[23:16] <= byte_in;
        2'd1: hold_q[15:8]  <= byte_in;
        2'd2: hold_q[7:0]   <= byte_in;
        2'd3: idx_q         <= idx_q + AW'(1);
      endcase
    end
  end

  // Memory is intentionally not reset; an aborted load keeps completed words.
  always_ff @(posedge clk) begin
    if (word_end) mem[idx_q] <= {hold_q, byte_in};
  end

  assign inst = mem[a[AW+1:2]];

  logic unused_a;
  assign unused_a = ^{a[31:AW+2], a[1:0]};

`ifdef SC_IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;
  logic       err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= 8'h00;
      err_q  <= 1'b0;
    end else if (start_ok) begin
      csum_q <= 8'h00;
      err_q  <= 1'b0;
    end else if ((state_q == StLoad) && xfer) begin
      csum_q <= csum_q ^ byte_in;
    end else if ((state_q == StCheck) && xfer) begin
      err_q <= (byte_in != csum_q);
    end
  end

  assign load_err = err_q;
`else
  assign load_err = 1'b0;
`endif

endmodule

// File: tb/tb_sc_imem_loader.sv
// Scoreboard bench for sc_imem_loader: words are queued as bytes are streamed and checked on fetch.
module tb_sc_imem_loader;

  localparam int unsigned AW    = 5;
  localparam int unsigned Depth = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic [AW:0]   load_len;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic [31:0]   a;
  logic [31:0]   inst;
  logic          busy;
  logic          done;
  logic          load_err;

  sc_imem_loader #(.AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_len   (load_len),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .a          (a),
    .inst       (inst),
    .busy       (busy),
    .done       (done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] mem_model [Depth];
  int          exp_addr [$];
  logic [31:0] exp_data [$];
  logic [31:0] words [$];
  logic [7:0]  csum;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte has been accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    byte_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      chk("ready_in_gap", 32'(byte_ready), 32'd1);
    end
    byte_in    = b;
    byte_valid = 1'b1;
    t = 0;
    while (!byte_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) chk("ready_timeout", 32'(byte_ready), 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic run_load(input logic [AW:0] len, input int gap, input bit mid_start,
                          input bit bad_cs);
    logic [7:0] b;
    int n;
    n    = words.size();
    csum = 8'h00;
    load_len   = len;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) begin
        b    = words[i][31-8*j -: 8];
        csum = csum ^ b;
        send_byte(b, gap);
        if (j == 3) begin
          exp_addr.push_back(i);
          exp_data.push_back(words[i]);
          mem_model[i] = words[i];
        end
        if (mid_start && i == 0 && j == 2) begin
          load_len   = 1;
          load_start = 1'b1;
          @(negedge clk);
          load_start = 1'b0;
          chk("busy_after_restart", 32'(busy), 32'd1);
        end
`ifdef SC_IMEM_LOADER_CHECKSUM_EN
        chk("done_early", 32'(done), 32'd0);
`else
        if (!(i == n - 1 && j == 3)) chk("done_early", 32'(done), 32'd0);
`endif
      end
    end
`ifdef SC_IMEM_LOADER_CHECKSUM_EN
    send_byte(csum ^ {7'd0, bad_cs}, 0);
    chk("load_err", 32'(load_err), 32'(bad_cs));
`else
    chk("load_err", 32'(load_err), 32'd0);
`endif
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("ready_at_done", 32'(byte_ready), 32'd0);
    // A start request during the done cycle must be dropped.
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_after_done", 32'(busy), 32'd0);
  endtask

  task automatic drain();
    int          ad;
    logic [31:0] d;
    while (exp_addr.size() > 0) begin
      ad = exp_addr.pop_front();
      d  = exp_data.pop_front();
      a  = $urandom();
      a[AW+1:2] = ad[AW-1:0];
      #1;
      chk("fetch", inst, d);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    rst        = 1'b1;
    load_start = 1'b0;
    load_len   = '0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    a          = 32'h0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(byte_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic load, valid held high
    words = {32'h3c01_0000, 32'h3424_0050};
    run_load(2, 0, 1'b0, 1'b0);
    drain();
    a = 32'h4; #1; chk("fetch_a4", inst, 32'h3424_0050);
    a = 32'h7; #1; chk("fetch_a7", inst, 32'h3424_0050);

    // Same stream with gaps
    words = {32'h3c01_0000, 32'h3424_0050};
    run_load(2, 3, 1'b0, 1'b0);
    drain();

    // Full-depth load via length 0, then via an oversize length
    words.delete();
    for (int k = 0; k < 32; k++) words.push_back(32'h0000_0100 * k + k);
    run_load(0, 0, 1'b0, 1'b0);
    drain();
    a = 32'h7c; #1; chk("fetch_top", inst, 32'h0000_1f1f);
    a = 32'h80; #1; chk("fetch_wrap", inst, 32'h0000_0000);
    words.delete();
    for (int k = 0; k < 32; k++) words.push_back(~(32'h0101_0101 * k));
    run_load(6'd40, 0, 1'b0, 1'b0);
    drain();

    // Reset after five transfers
    words = {32'haabb_ccdd, 32'h1122_3344};
    load_len   = 2;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b = words[i / 4][31-8*(i % 4) -: 8];
      send_byte(b, 0);
    end
    mem_model[0] = 32'haabb_ccdd;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(byte_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end
    a = 32'h0; #1; chk("abort_mem0", inst, mem_model[0]);
    a = 32'h4; #1; chk("abort_mem1", inst, mem_model[1]);

    // Second start request mid-load
    words = {32'hcafe_f00d, 32'h0bad_beef};
    run_load(2, 0, 1'b1, 1'b0);
    drain();

`ifdef SC_IMEM_LOADER_CHECKSUM_EN
    words = {32'h1234_5678};
    run_load(1, 0, 1'b0, 1'b0);
    drain();
    run_load(1, 0, 1'b0, 1'b1);
    drain();
    repeat (3) @(negedge clk);
    chk("err_hold", 32'(load_err), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
